// File: rtl/link_distributor.sv
// Egress distributor: fans a single drained word stream out to four links, each with a
// small FIFO. Routes by header destination, or stripes round-robin in multi_width mode.
module link_distributor #(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned LINK_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  multi_width,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic                  out_valid0,
  output logic                  out_valid1,
  output logic                  out_valid2,
  output logic                  out_valid3,
  input  logic                  out_ready0,
  input  logic                  out_ready1,
  input  logic                  out_ready2,
  input  logic                  out_ready3,
  output logic [3:0]            link_full
);

  localparam int unsigned NumLinks = 4;
  localparam int unsigned PtrW     = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(LINK_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(LINK_DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t           mem_q    [NumLinks][LINK_DEPTH];
  word_t           mem_d    [NumLinks][LINK_DEPTH];
  logic [PtrW-1:0] wr_ptr_q [NumLinks];
  logic [PtrW-1:0] wr_ptr_d [NumLinks];
  logic [PtrW-1:0] rd_ptr_q [NumLinks];
  logic [PtrW-1:0] rd_ptr_d [NumLinks];
  logic [CntW-1:0] cnt_q    [NumLinks];
  logic [CntW-1:0] cnt_d    [NumLinks];
  logic [1:0]      stripe_ptr_q;
  logic [1:0]      stripe_ptr_d;

  logic [1:0]          dest;
  logic                push;
  logic [NumLinks-1:0] push_sel;
  logic [NumLinks-1:0] full;
  logic [NumLinks-1:0] nonempty;
  logic [NumLinks-1:0] out_ready_v;
  logic [NumLinks-1:0] pop;
  word_t               head     [NumLinks];
  word_t               out_data [NumLinks];
  logic [NumLinks-1:0] out_valid;

  assign out_ready_v = {out_ready3, out_ready2, out_ready1, out_ready0};

  always_comb begin
    for (int k = 0; k < NumLinks; k++) begin
      full[k]     = (cnt_q[k] == DepthCnt);
      nonempty[k] = (cnt_q[k] != '0);
      head[k]     = mem_q[k][rd_ptr_q[k]];
    end
  end

  // Full is judged on the pre-pop count, so a full link refuses a push even while draining.
  assign dest     = multi_width ? stripe_ptr_q : in_data[DATA_WIDTH-1 -: 2];
  assign in_ready = !rst && !full[dest];
  assign push     = in_valid && in_ready;
  assign pop      = nonempty & out_ready_v;

  always_comb begin
    push_sel = '0;
    if (push) begin
      push_sel[dest] = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < NumLinks; k++) begin
      if (push_sel[k]) begin
        mem_d[k][wr_ptr_q[k]] = in_data;
        wr_ptr_d[k]           = wr_ptr_q[k] + PtrW'(1);
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PtrW'(1);
      end
      if (push_sel[k] && !pop[k]) begin
        cnt_d[k] = cnt_q[k] + CntW'(1);
      end else if (!push_sel[k] && pop[k]) begin
        cnt_d[k] = cnt_q[k] - CntW'(1);
      end
    end
  end

  // Held at 0 outside striping so every striping run begins on link 0.
  always_comb begin
    stripe_ptr_d = stripe_ptr_q;
    if (!multi_width) begin
      stripe_ptr_d = '0;
    end else if (push) begin
      stripe_ptr_d = stripe_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NumLinks; k++) begin
        for (int j = 0; j < LINK_DEPTH; j++) begin
          mem_q[k][j] <= '0;
        end
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      stripe_ptr_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      stripe_ptr_q <= stripe_ptr_d;
    end
  end

  // Outputs read as idle for the whole time rst is high, not just after the reset edge.
  always_comb begin
    out_valid = nonempty & {NumLinks{!rst}};
    link_full = full & {NumLinks{!rst}};
    for (int k = 0; k < NumLinks; k++) begin
      out_data[k] = rst ? '0 : head[k];
    end
  end

  assign out_data0  = out_data[0];
  assign out_data1  = out_data[1];
  assign out_data2  = out_data[2];
  assign out_data3  = out_data[3];
  assign out_valid0 = out_valid[0];
  assign out_valid1 = out_valid[1];
  assign out_valid2 = out_valid[2];
  assign out_valid3 = out_valid[3];

endmodule
